// File: rtl/tmds_video_timing.sv
// Pixel-clock video timing generator: qualifies the TMDS PLL lock, then runs
// the raster counters and emits registered hsync/vsync/DE/x/y for the encoder.
module tmds_video_timing #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter int unsigned HS_POL    = 1,
  parameter int unsigned VS_POL    = 1,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        lock,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        timing_active
);

  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned LCW     = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  localparam logic [CW-1:0]  H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]  V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]  H_ACT     = CW'(H_ACTIVE);
  localparam logic [CW-1:0]  V_ACT     = CW'(V_ACTIVE);
  localparam logic [CW-1:0]  HS_START  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]  HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]  VS_START  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]  VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);
  localparam logic           HS_ON     = 1'(HS_POL);
  localparam logic           VS_ON     = 1'(VS_POL);

  // Elaboration-time guard: totals must fit the 12-bit counters.
  if (H_TOTAL > 4095 || V_TOTAL > 4095 || LOCK_WAIT < 1) begin : g_bad_params
    $error("tmds_video_timing: invalid timing parameters");
  end

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [LCW-1:0]  lock_cnt, lock_cnt_n;
  logic [CW-1:0]   h_cnt, h_cnt_n;
  logic [CW-1:0]   v_cnt, v_cnt_n;
  logic            lock_m, lock_s;
  logic            run_ok;
  logic            de_pix;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
    end
  end

  // State, lock qualifier and raster counter registers.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_cnt_n;
      h_cnt    <= h_cnt_n;
      v_cnt    <= v_cnt_n;
    end
  end

  // Next-state: qualify lock, then walk the raster; lock loss beats wrap.
  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    h_cnt_n    = h_cnt;
    v_cnt_n    = v_cnt;
    run_ok     = 1'b0;
    case (state)
      WAIT_LOCK: begin
        h_cnt_n = '0;
        v_cnt_n = '0;
        if (!lock_s) begin
          lock_cnt_n = '0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_n    = RUN;
          lock_cnt_n = '0;
        end else begin
          lock_cnt_n = lock_cnt + LCW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_n    = WAIT_LOCK;
          lock_cnt_n = '0;
          h_cnt_n    = '0;
          v_cnt_n    = '0;
        end else begin
          run_ok = 1'b1;
          if (h_cnt == H_LAST) begin
            h_cnt_n = '0;
            v_cnt_n = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
          end else begin
            h_cnt_n = h_cnt + CW'(1);
          end
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  assign de_pix = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // Registered decode; idles at reset values unless running with lock present.
  always_ff @(posedge clkin) begin
    if (reset || !run_ok) begin
      hsync         <= ~HS_ON;
      vsync         <= ~VS_ON;
      de            <= 1'b0;
      x             <= '0;
      y             <= '0;
      frame_start   <= 1'b0;
      timing_active <= 1'b0;
    end else begin
      hsync         <= (h_cnt >= HS_START && h_cnt < HS_END) ? HS_ON : ~HS_ON;
      vsync         <= (v_cnt >= VS_START && v_cnt < VS_END) ? VS_ON : ~VS_ON;
      de            <= de_pix;
      x             <= de_pix ? h_cnt : '0;
      y             <= de_pix ? v_cnt : '0;
      frame_start   <= (h_cnt == '0) && (v_cnt == '0);
      timing_active <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tmds_video_timing.sv
// Directed bench for tmds_video_timing using a shrunken raster (15x8, lock wait 16)
// so whole frames and re-qualifications fit in a short run.
module tb_tmds_video_timing;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int LW = 16;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 8

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        lock  = 1'b0;
  logic        hsync, vsync, de, frame_start, timing_active;
  logic [11:0] x, y;

  int checks   = 0;
  int failures = 0;
  int n;
  int de_n, hs_n, vs_n, fs_n;

  tmds_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .LOCK_WAIT(LW)
  ) dut (
    .clkin(clkin), .reset(reset), .lock(lock),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .timing_active(timing_active)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle 1 ns past the edge before sampling/driving.
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_de"},  32'(de), 0);
    check({tag, "_hs"},  32'(hsync), 0);
    check({tag, "_vs"},  32'(vsync), 0);
    check({tag, "_x"},   32'(x), 0);
    check({tag, "_y"},   32'(y), 0);
    check({tag, "_fs"},  32'(frame_start), 0);
    check({tag, "_ta"},  32'(timing_active), 0);
  endtask

  // Expected outputs for the pixel position (h, v) one cycle earlier.
  task automatic check_pix(input string tag, input int h, input int v);
    logic ede;
    ede = (h < HA) && (v < VA);
    check({tag, "_de"}, 32'(de), 32'(ede));
    check({tag, "_hs"}, 32'(hsync), 32'((h >= HA + HF) && (h < HA + HF + HS)));
    check({tag, "_vs"}, 32'(vsync), 32'((v >= VA + VF) && (v < VA + VF + VS)));
    check({tag, "_x"},  32'(x), ede ? 32'(h) : 0);
    check({tag, "_y"},  32'(y), ede ? 32'(v) : 0);
    check({tag, "_fs"}, 32'(frame_start), 32'((h == 0) && (v == 0)));
    check({tag, "_ta"}, 32'(timing_active), 1);
  endtask

  // Count edges until timing_active rises (bounded); outputs must stay idle meanwhile.
  task automatic wait_active(input string tag, output int edges);
    int bad;
    edges = 0;
    bad   = 0;
    while (timing_active !== 1'b1 && edges < 200) begin
      tick();
      edges++;
      if (timing_active !== 1'b1 &&
          (de !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b0 || frame_start !== 1'b0 ||
           x !== 12'd0 || y !== 12'd0))
        bad++;
    end
    check({tag, "_idle_violations"}, 32'(bad), 0);
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    lock  = 1'b0;
    repeat (3) tick();
    check_idle("reset");

    // Lock qualification: 2 sync + LW qualify + 1 output register = LW+3 edges.
    reset = 1'b0;
    lock  = 1'b1;
    wait_active("qual", n);
    check("qual_latency", 32'(n), 32'(LW + 3));
    check_pix("first_px", 0, 0);

    // One full frame plus the next (0,0): per-pixel decode and aggregate counts.
    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    for (int t = 1; t <= HT * VT; t++) begin
      tick();
      check_pix("frame", t % HT, (t / HT) % VT);
      de_n += int'(de);
      hs_n += int'(hsync);
      vs_n += int'(vsync);
      fs_n += int'(frame_start);
    end
    check("frame_de_cycles", 32'(de_n), 32'd32);
    check("frame_hs_cycles", 32'(hs_n), 32'd24);
    check("frame_vs_cycles", 32'(vs_n), 32'd30);
    check("frame_fs_pulses", 32'(fs_n), 32'd1);
    check("frame_fs_at_period", 32'(frame_start), 1);

    // Move to line 2, pixel 5, then drop lock.
    repeat (35) tick();
    check_pix("pre_loss", 5, 2);
    lock = 1'b0;
    tick();
    check("loss_e1_ta", 32'(timing_active), 1);
    tick();
    check("loss_e2_ta", 32'(timing_active), 1);
    tick();
    check_idle("loss_e3");
    repeat (3) tick();
    check_idle("loss_hold");

    // Glitch: 14 high, 1 low, then high; qualification restarts after the glitch.
    lock = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("glitch_pre_ta", 32'(timing_active), 0);
    end
    lock = 1'b0;
    tick();
    check("glitch_low_ta", 32'(timing_active), 0);
    lock = 1'b1;
    wait_active("glitch", n);
    check("glitch_latency", 32'(n), 32'(LW + 3));
    check_pix("glitch_restart", 0, 0);

    // Reset mid-frame with lock held high.
    repeat (40) tick();
    check_pix("pre_reset", 10, 2);
    reset = 1'b1;
    tick();
    check_idle("reset_mid");
    reset = 1'b0;
    wait_active("reset_requal", n);
    check("reset_latency", 32'(n), 32'(LW + 3));
    check_pix("reset_restart", 0, 0);
    tick();
    check_pix("reset_next", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
